hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter AW, default 5: register address width (2^AW registers).
REQ-002 SHALL take parameter NSTAGE, default 3: number of in-flight stages tracked (ID, EXE, MEM).
REQ-003 SHALL take parameter LONG_LAT, default 32: cycles a long-latency (mul/div) write stays pending.
REQ-004 SHALL take parameter CW, default 16: stall counter width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports clk (in, 1) and rst (in, 1).
REQ-006 issue_valid  in  1  fetched instruction present for hazard check.
REQ-007 issue_rs, issue_rt  in  AW each  source register addresses.
REQ-008 issue_rs_used, issue_rt_used  in  1 each  corresponding source is actually read.
REQ-009 issue_we, issue_waddr  in  1, AW  instruction writes the register file at waddr.
REQ-010 issue_long  in  1  instruction is a long-latency op writing waddr.
REQ-011 flush  in  1  discard all tracked short in-flight writes (branch/exception).
REQ-012 if_stop  out  1  hold IF/PC this cycle and insert a bubble.
REQ-013 long_busy  out  1  a long op is pending.
REQ-014 stall_cnt  out  CW  saturating count of stalled cycles.

Function
REQ-015 SHALL keep NSTAGE slots {valid, waddr}; slot 0 is the youngest.
- Slots valid only when we=1 and waddr != 0.
REQ-016 Accept = issue_valid && !if_stop && !flush.
- Each rising edge: slot i+1 <= slot i, and slot NSTAGE-1 retires.
- Slot 0 <= accepted issue entry; otherwise slot 0 <= bubble.
- Any issue_long instruction enters slot 0 as a bubble.
REQ-017 SHALL assert if_stop combinationally in the same cycle when issue_valid=1 and either condition holds:
- a used source (rs/rt, nonzero) equals the waddr of ANY valid slot;
- a used source equals a pending long_waddr.
REQ-018 SHALL check all slots and the long entry with equal weight; a mismatch in one slot SHALL NOT mask a match in another.
REQ-019 SHALL also assert if_stop when issue_valid && issue_long && long_busy (structural hazard).
REQ-020 SHALL also assert if_stop when issue_valid && issue_we && long_busy && issue_waddr == long_waddr (WAW hazard).
REQ-021 SHALL hold if_stop at 0 whenever issue_valid=0.
REQ-022 On an accepted issue_long:
- long counter <= LONG_LAT and long_waddr <= issue_waddr;
- counter decrements each edge while nonzero;
- long_busy = (counter != 0);
- a long op with waddr 0 still sets busy but never causes a RAW/WAW stall.
REQ-023 A hazard on slot/long entry written at edge t SHALL be visible from cycle t+1.
- Short entries stay visible through cycle t+NSTAGE.
- Long entries stay visible through cycle t+LONG_LAT.
REQ-024 flush SHALL clear all slots at the next edge and block acceptance in the same cycle.
- flush wins over a simultaneous issue.
- flush SHALL NOT cancel an already-started long op.
REQ-025 stall_cnt SHALL increment by 1 on each edge where if_stop=1 and SHALL saturate at 2^CW-1.

Reset
REQ-026 On rst at a rising edge, SHALL clear:
- all slots invalid;
- long counter 0 and long_waddr 0;
- stall_cnt 0.
REQ-027 During and after reset, SHALL drive long_busy=0 and stall_cnt=0.
- if_stop follows REQ-017..021, so it is 0 with no pending state.
REQ-028 rst SHALL take priority over flush and issue.
- A long op in progress SHALL be aborted.

Structure
REQ-029 SHALL place AW, NSTAGE, LONG_LAT and CW defaults and the slot record typedef {valid, waddr} in the shared CPU package.
REQ-030 SHALL implement the RAW compare (two sources vs one entry, with used and nonzero qualifiers) as one sub-module, hazard_match, instantiated NSTAGE+1 times.

Verification
REQ-031 Issue we=1 waddr=5, then rs=5 used:
- if_stop=1 for 3 cycles, then 0;
- stall_cnt=3.
REQ-032 Slots hold waddr 7 (slot 0) and 9 (slot 2); issue rs=4, rt=9 used -> if_stop=1 (the older-slot match is not masked).
REQ-033 Issue writing r0, then rs=0 used -> if_stop=0.
REQ-034 Issue rs=6 with rs_used=0 while a slot holds 6 -> if_stop=0.
REQ-035 Accept long op waddr=8 with LONG_LAT=32:
- dependent rs=8 stalls exactly 32 cycles;
- a second long op stalls while long_busy=1.
REQ-036 flush while slots hold 3 and 4 and an issue is valid:
- next cycle, a reader of r3/r4 is not stalled;
- the flushed issue did not enter slot 0;
- a pending long op survives.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU package: hazard scoreboard defaults and the in-flight slot record.
// Slot addresses are stored at MAX_AW bits so the record is independent of the instance's AW.
package hazard_scoreboard_pkg;

    localparam int DEF_AW       = 5;
    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_LONG_LAT = 32;
    localparam int DEF_CW       = 16;
    localparam int MAX_AW       = 8;

    typedef logic [MAX_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t waddr;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, waddr: '0};

    // Register 0 is hardwired, so a write to it never produces a tracked entry.
    function automatic slot_t make_slot(input logic we, input reg_addr_t waddr);
        return '{valid: we && (waddr != '0), waddr: waddr};
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the decode stage and the hazard scoreboard.
interface hazard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
);
    logic          issue_valid;
    logic [AW-1:0] issue_rs;
    logic [AW-1:0] issue_rt;
    logic          issue_rs_used;
    logic          issue_rt_used;
    logic          issue_we;
    logic [AW-1:0] issue_waddr;
    logic          issue_long;
    logic          flush;
    logic          if_stop;
    logic          long_busy;
    logic [CW-1:0] stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_we, issue_waddr, issue_long, flush,
        input  if_stop, long_busy, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_we, issue_waddr, issue_long, flush,
        output if_stop, long_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// RAW compare of both issue sources against one tracked write entry.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          rs_used,
    input  logic          rt_used,
    input  slot_t         entry,
    output logic          match
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = rs_used && (rs != '0) && (reg_addr_t'(rs) == entry.waddr);
    assign rt_hit = rt_used && (rt != '0) && (reg_addr_t'(rt) == entry.waddr);
    assign match  = entry.valid && (entry.waddr != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: short writes tracked through NSTAGE slots,
// one long-latency write tracked by a down-counter, IF stop on RAW/WAW/structural hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int LONG_LAT = DEF_LONG_LAT,
    parameter int CW       = DEF_CW
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave bus
);
    localparam int LCW = $clog2(LONG_LAT + 1);

    slot_t          slots [NSTAGE];
    slot_t          new_slot;
    slot_t          long_entry;
    logic [LCW-1:0] long_cnt;
    reg_addr_t      long_waddr;
    logic [CW-1:0]  stall_q;
    logic [NSTAGE:0] hit;
    logic           long_busy;
    logic           waw_hz;
    logic           struct_hz;
    logic           if_stop;
    logic           accept;

    assign long_busy  = (long_cnt != '0);
    assign long_entry = '{valid: long_busy, waddr: long_waddr};

    // Every slot plus the long entry gets its own comparator; hits are OR-ed flat.
    for (genvar i = 0; i <= NSTAGE; i++) begin : g_match
        hazard_match #(.AW(AW)) u_match (
            .rs      (bus.issue_rs),
            .rt      (bus.issue_rt),
            .rs_used (bus.issue_rs_used),
            .rt_used (bus.issue_rt_used),
            .entry   ((i == NSTAGE) ? long_entry : slots[(i == NSTAGE) ? 0 : i]),
            .match   (hit[i])
        );
    end

    assign struct_hz = bus.issue_long && long_busy;
    assign waw_hz    = bus.issue_we && long_busy && (long_waddr != '0)
                       && (reg_addr_t'(bus.issue_waddr) == long_waddr);
    assign if_stop   = bus.issue_valid && ((|hit) || struct_hz || waw_hz);
    assign accept    = bus.issue_valid && !if_stop && !bus.flush;

    // Long ops are tracked only by the counter, so they enter the pipe as a bubble.
    always_comb begin
        new_slot = SLOT_BUBBLE;
        if (accept && !bus.issue_long) begin
            new_slot = make_slot(bus.issue_we, reg_addr_t'(bus.issue_waddr));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < NSTAGE; i++) begin
                slots[i] <= SLOT_BUBBLE;
            end
        end else begin
            slots[0] <= new_slot;
            for (int i = 1; i < NSTAGE; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Flush leaves a started long op running; only reset aborts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt   <= '0;
            long_waddr <= '0;
        end else if (accept && bus.issue_long) begin
            long_cnt   <= LCW'(LONG_LAT);
            long_waddr <= reg_addr_t'(bus.issue_waddr);
        end else if (long_cnt != '0) begin
            long_cnt <= long_cnt - LCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (if_stop && (stall_q != '1)) begin
            stall_q <= stall_q + CW'(1);
        end
    end

    assign bus.if_stop   = if_stop;
    assign bus.long_busy = long_busy;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int LAT     = 32;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic          stop;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t  exp_q [$];
    string name_q [$];
    int    checks   = 0;
    int    failures = 0;
    int    exp_cnt  = 0;

    always #5 clk = ~clk;

    hazard_if #(.AW(AW), .CW(CW)) bus ();

    hazard_scoreboard #(
        .AW(AW), .NSTAGE(3), .LONG_LAT(LAT), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input string field,
                               input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s %s actual=%0d required=%0d", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checkOutput(n, "if_stop",   16'(bus.if_stop),   16'(e.stop));
            checkOutput(n, "long_busy", 16'(bus.long_busy), 16'(e.busy));
            checkOutput(n, "stall_cnt", 16'(bus.stall_cnt), 16'(e.cnt));
        end
    end

    // Drive one cycle of inputs and queue what the outputs must show in that cycle.
    task automatic applyStimulus(input bit r, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                                 input bit rsu, input bit rtu, input bit we, input bit [4:0] wa,
                                 input bit lng, input bit fl, input bit es, input bit eb,
                                 input bit push, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bus.issue_valid   = v;
        bus.issue_rs      = rs;
        bus.issue_rt      = rt;
        bus.issue_rs_used = rsu;
        bus.issue_rt_used = rtu;
        bus.issue_we      = we;
        bus.issue_waddr   = wa;
        bus.issue_long    = lng;
        bus.flush         = fl;
        if (push) begin
            e.stop = es;
            e.busy = eb;
            e.cnt  = CW'(exp_cnt);
            exp_q.push_back(e);
            name_q.push_back(name);
        end
        if (r) exp_cnt = 0;
        else if (es && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic idle(input bit eb, input string name);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb, 1, name);
    endtask

    task automatic rd(input bit [4:0] rs, input bit [4:0] rt, input bit rsu, input bit rtu,
                      input bit es, input bit eb, input string name);
        applyStimulus(0, 1, rs, rt, rsu, rtu, 0, 0, 0, 0, es, eb, 1, name);
    endtask

    task automatic wr(input bit [4:0] wa, input bit es, input bit eb, input string name);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, wa, 0, 0, es, eb, 1, name);
    endtask

    initial begin
        #100000;
        $display("[TB] timeout: bench did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.issue_valid = 0; bus.issue_rs = 0; bus.issue_rt = 0;
        bus.issue_rs_used = 0; bus.issue_rt_used = 0; bus.issue_we = 0;
        bus.issue_waddr = 0; bus.issue_long = 0; bus.flush = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_first");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");

        // Back-to-back dependency: three stall cycles, then release.
        wr(5, 0, 0, "raw_write5");
        for (int i = 0; i < 3; i++) rd(5, 0, 1, 0, 1, 0, "raw_stall5");
        rd(5, 0, 1, 0, 0, 0, "raw_release5");
        idle(0, "raw_cnt3");

        // Slot0=7, slot1=bubble, slot2=9: the rt match on the oldest slot must win.
        wr(9, 0, 0, "mask_write9");
        idle(0, "mask_gap");
        wr(7, 0, 0, "mask_write7");
        rd(4, 9, 1, 1, 1, 0, "mask_older_slot");
        applyStimulus(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "novalid_no_stop");
        idle(0, "drain_a");
        idle(0, "drain_b");

        wr(0, 0, 0, "r0_write");
        rd(0, 0, 1, 1, 0, 0, "r0_read");

        wr(6, 0, 0, "unused_write6");
        rd(6, 6, 0, 0, 0, 0, "unused_src");
        rd(6, 0, 1, 0, 1, 0, "used_src_ctrl");
        idle(0, "drain_c");
        idle(0, "drain_d");

        // Long op: dependent read stalls exactly LAT cycles.
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 1, "long_issue8");
        for (int i = 0; i < LAT; i++) rd(8, 0, 1, 0, 1, 1, "long_raw8");
        rd(8, 0, 1, 0, 0, 0, "long_release8");

        applyStimulus(0, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 1, "long_issue10");
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 11, 1, 0, 1, 1, 1, "long_structural");
        wr(10, 1, 1, "long_waw10");
        rd(10, 0, 1, 0, 1, 1, "long_raw10");
        wr(12, 0, 1, "long_indep_write");

        // Flush with slots holding 3 and 4 and a valid issue of r5.
        wr(3, 0, 1, "flush_write3");
        wr(4, 0, 1, "flush_write4");
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 1, 1, "flush_cycle");
        rd(3, 4, 1, 1, 0, 1, "flush_cleared");
        rd(5, 0, 1, 0, 0, 1, "flush_not_entered");
        rd(10, 0, 1, 0, 1, 1, "flush_long_survives");

        // Reset aborts the running long op.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "rst_cycle");
        idle(0, "rst_abort");
        rd(10, 0, 1, 0, 0, 0, "rst_no_raw");

        // Long op to r0: busy, but no WAW against r0.
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, "long_r0_issue");
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, "long_r0_no_waw");
        idle(1, "long_r0_busy");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
